// File: rtl/ram_arbiter_controller.sv
// ----------------------------------------------------------------------------
// ram_arbiter_controller
//
// Round-robin arbiter that shares one external asynchronous-style SRAM
// (8-bit low byte lane) between N_PORTS requesters. Each accepted access runs
// through a fixed three-stage pipeline:
//   T   : grant (combinational gnt pulse), request captured
//   T+1 : address phase  (address driven, ce1_n low, we1_n or oe_n low)
//   T+2 : data phase     (ce1_n low; write drives bus with bwa_n low,
//                         read samples the bus at the end of the cycle)
//   T+3 : read result    (rvalid pulse + datar)
// Same-direction accesses stream back to back; a direction change costs one
// bubble cycle so the RAM and the controller never fight over the bus.
//
// Ports
//   clk                 : single clock, rising edge
//   reset_n             : asynchronous active-low reset
//   req[N]              : per-port request, held until granted
//   we_n[N]             : per-port direction (0 = write, 1 = read)
//   address[N*ADDR_W]   : per-port address, port i at [i*ADDR_W +: ADDR_W]
//   dataw[N*DATA_W]     : per-port write data, port i at [i*DATA_W +: DATA_W]
//   gnt[N]              : one-hot single-cycle grant
//   rvalid[N]           : one-hot single-cycle read-data-valid
//   datar[DATA_W]       : read data, meaningful while rvalid is non-zero
//   ce1_n/oe_n/we1_n/bwa_n : active-low RAM strobes
//   address_ram_output  : registered RAM address (holds when idle)
//   data_ram_output     : bidirectional RAM data bus
// ----------------------------------------------------------------------------
module ram_arbiter_controller #(
    parameter int DATA_W  = 8,
    parameter int ADDR_W  = 19,
    parameter int N_PORTS = 2
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [N_PORTS-1:0]          req,
    input  logic [N_PORTS-1:0]          we_n,
    input  logic [N_PORTS*ADDR_W-1:0]   address,
    input  logic [N_PORTS*DATA_W-1:0]   dataw,
    output logic [N_PORTS-1:0]          gnt,
    output logic [N_PORTS-1:0]          rvalid,
    output logic [DATA_W-1:0]           datar,
    output logic                        ce1_n,
    output logic                        oe_n,
    output logic                        we1_n,
    output logic                        bwa_n,
    output logic [ADDR_W-1:0]           address_ram_output,
    inout  wire  [DATA_W-1:0]           data_ram_output
);

    localparam int PTR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        TURN = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;

    logic               found;
    logic [PTR_W-1:0]   cand;
    logic               cand_wr;
    logic               blocked;
    logic               grant;

    logic               vld_p1_q, vld_p1_d;
    logic               wr_p1_q, wr_p1_d;
    logic [PTR_W-1:0]   port_p1_q, port_p1_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_p1_q;

    logic               vld_p2_q, vld_p2_d;
    logic               wr_p2_q, wr_p2_d;
    logic [PTR_W-1:0]   port_p2_q, port_p2_d;
    logic [DATA_W-1:0]  wdata_p2_q;

    logic [N_PORTS-1:0] rvalid_q, rvalid_d;
    logic [DATA_W-1:0]  datar_q, datar_d;

    // ------------------------------------------------------------------
    // Stage T: round-robin pick starting at the priority pointer
    // ------------------------------------------------------------------
    always_comb begin : arbitrate
        int idx;
        idx   = 0;
        found = 1'b0;
        cand  = '0;
        for (int j = 0; j < N_PORTS; j++) begin
            idx = int'(ptr_q) + j;
            if (idx >= N_PORTS) begin
                idx = idx - N_PORTS;
            end
            if (!found && req[PTR_W'(idx)]) begin
                found = 1'b1;
                cand  = PTR_W'(idx);
            end
        end
    end

    assign cand_wr = ~we_n[cand];

    // A grant right after an opposite-direction grant is held off for one
    // cycle; the waiting port stays at the head because the pointer is frozen.
    always_comb begin : turnaround
        blocked = 1'b0;
        case (state_q)
            RD:      blocked = cand_wr;
            WR:      blocked = ~cand_wr;
            default: blocked = 1'b0;
        endcase
    end

    assign grant = reset_n & found & ~blocked;

    always_comb begin : grant_decode
        gnt = '0;
        if (grant) begin
            gnt[cand] = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_d = IDLE;
        ptr_d   = ptr_q;
        if (grant) begin
            state_d = cand_wr ? WR : RD;
            ptr_d   = (int'(cand) == N_PORTS - 1) ? '0 : cand + PTR_W'(1);
        end else if (found && blocked) begin
            state_d = TURN;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage T -> T+1 (address phase) and T+1 -> T+2 (data phase)
    // ------------------------------------------------------------------
    always_comb begin : pipe_next
        vld_p1_d  = grant;
        wr_p1_d   = wr_p1_q;
        port_p1_d = port_p1_q;
        addr_d    = addr_q;
        if (grant) begin
            wr_p1_d   = cand_wr;
            port_p1_d = cand;
            addr_d    = address[cand*ADDR_W +: ADDR_W];
        end

        vld_p2_d  = vld_p1_q;
        wr_p2_d   = wr_p1_q;
        port_p2_d = port_p1_q;

        rvalid_d  = '0;
        datar_d   = datar_q;
        if (vld_p2_q && !wr_p2_q) begin
            rvalid_d[port_p2_q] = 1'b1;
            datar_d             = data_ram_output;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1_q  <= 1'b0;
            wr_p1_q   <= 1'b0;
            port_p1_q <= '0;
            addr_q    <= '0;
            vld_p2_q  <= 1'b0;
            wr_p2_q   <= 1'b0;
            port_p2_q <= '0;
            rvalid_q  <= '0;
            datar_q   <= '0;
        end else begin
            vld_p1_q  <= vld_p1_d;
            wr_p1_q   <= wr_p1_d;
            port_p1_q <= port_p1_d;
            addr_q    <= addr_d;
            vld_p2_q  <= vld_p2_d;
            wr_p2_q   <= wr_p2_d;
            port_p2_q <= port_p2_d;
            rvalid_q  <= rvalid_d;
            datar_q   <= datar_d;
        end
    end

    // Write data only matters while vld_p2_q/wr_p2_q enable the bus driver,
    // and those are cleared by reset, so the data itself needs no reset.
    always_ff @(posedge clk) begin
        if (grant) begin
            wdata_p1_q <= dataw[cand*DATA_W +: DATA_W];
        end
        wdata_p2_q <= wdata_p1_q;
    end

    // ------------------------------------------------------------------
    // RAM-facing strobes decoded from the phase flags
    // ------------------------------------------------------------------
    assign ce1_n = ~(vld_p1_q | vld_p2_q);
    assign oe_n  = ~(vld_p1_q & ~wr_p1_q);
    assign we1_n = ~(vld_p1_q & wr_p1_q);
    assign bwa_n = ~(vld_p2_q & wr_p2_q);

    assign address_ram_output = addr_q;
    assign data_ram_output    = (vld_p2_q && wr_p2_q) ? wdata_p2_q : {DATA_W{1'bz}};

    // ------------------------------------------------------------------
    // Stage T+3: read result
    // ------------------------------------------------------------------
    assign rvalid = rvalid_q;
    assign datar  = datar_q;

endmodule
